// File: rtl/shader_raster_seq.sv
// shader_raster_seq: VGA raster sequencer for the tiny shader pipeline.
// A single h/v counter pair drives sync, blanking and line/frame strobes.
// The shader memory/executor is sequenced one cell (NUM_INSTR clocks) ahead
// of the beam. Each finished cell colour is latched for display on the next
// NUM_INSTR pixels. A frame-stepped 8-bit time value with selectable modes
// is also kept here.
// Optional feature: define SHADER_RASTER_GRID_EN to add the grid_i overlay.
module shader_raster_seq #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int HFRONT    = 16,
  parameter int HSYNC     = 96,
  parameter int HBACK     = 48,
  parameter int VFRONT    = 10,
  parameter int VSYNC     = 2,
  parameter int VBACK     = 33,
  parameter bit SYNC_POL  = 1'b1,
  parameter int NUM_INSTR = 12,
  parameter int COLOR_W   = 6
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [1:0]                             time_mode_i,
  input  logic [COLOR_W-1:0]                     rgb_i,
`ifdef SHADER_RASTER_GRID_EN
  input  logic                                   grid_i,
`endif
  output logic                                   execute_o,
  output logic [$clog2(NUM_INSTR)-1:0]           sub_o,
  output logic [$clog2(WIDTH/NUM_INSTR)-1:0]     x_pos_o,
  output logic [$clog2(HEIGHT/NUM_INSTR)-1:0]    y_pos_o,
  output logic [7:0]                             time_o,
  output logic                                   hsync_o,
  output logic                                   vsync_o,
  output logic                                   next_line_o,
  output logic                                   next_frame_o,
  output logic [COLOR_W-1:0]                     rgb_o
);

  localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;
  localparam int CW     = WIDTH / NUM_INSTR;
  localparam int CH     = HEIGHT / NUM_INSTR;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int SW     = $clog2(NUM_INSTR);
  localparam int XW     = $clog2(CW);
  localparam int YW     = $clog2(CH);

  // All position comparisons are done on zero-extended 32-bit values so that
  // bounds equal to a power of two never overflow the counter width.
  localparam logic [31:0] H_LAST    = 32'(HTOTAL - 1);
  localparam logic [31:0] V_LAST    = 32'(VTOTAL - 1);
  localparam logic [31:0] H_LA_PRE  = 32'(HTOTAL - NUM_INSTR - 1);
  localparam logic [31:0] H_LA_WRAP = 32'(HTOTAL - NUM_INSTR);
  localparam logic [31:0] H_CELLS   = 32'(CW * NUM_INSTR);
  localparam logic [31:0] V_CELLS   = 32'(CH * NUM_INSTR);
  localparam logic [31:0] H_EXE_END = 32'(CW * NUM_INSTR - NUM_INSTR);
  localparam logic [31:0] H_VIS     = 32'(WIDTH);
  localparam logic [31:0] V_VIS     = 32'(HEIGHT);
  localparam logic [31:0] HS_START  = 32'(WIDTH + HFRONT);
  localparam logic [31:0] HS_END    = 32'(WIDTH + HFRONT + HSYNC);
  localparam logic [31:0] VS_START  = 32'(HEIGHT + VFRONT);
  localparam logic [31:0] VS_END    = 32'(HEIGHT + VFRONT + VSYNC);

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic [VW-1:0]      lv_cnt;
  logic [SW-1:0]      ly_sub;
  logic [YW-1:0]      ly_cell;
  logic               armed;
  logic [SW-1:0]      sub_q;
  logic [XW-1:0]      x_q;
  logic [COLOR_W-1:0] rgb_p1;
  logic               vld_p0;
  logic [7:0]         time_q;
  logic               dir_down;

  logic [31:0] h_w, v_w, lv_w;
  logic        line_end, v_last, la_pre, la_in, last_slot, vis;

  assign h_w  = 32'(h_cnt);
  assign v_w  = 32'(v_cnt);
  assign lv_w = 32'(lv_cnt);

  assign line_end = (h_w == H_LAST);
  assign v_last   = (v_w == V_LAST);
  // Clock after which the lookahead column wraps to la=0 and lv moves on.
  assign la_pre   = (h_w == H_LA_PRE);

  // Next step of the frame time for the given mode; returns {dir_down, time}.
  function automatic logic [8:0] time_step(input logic [1:0] mode,
                                           input logic [7:0] t,
                                           input logic       down);
    logic [7:0] nt;
    logic       nd;
    nt = t;
    nd = down;
    case (mode)
      2'b01: nt = t + 8'd1;
      2'b11: nt = t - 8'd1;
      2'b10: begin
        nt = down ? (t - 8'd1) : (t + 8'd1);
        if (nt == 8'hFF)      nd = 1'b1;
        else if (nt == 8'h00) nd = 1'b0;
      end
      default: ;
    endcase
    return {nd, nt};
  endfunction

  // Beam counters: h runs over the whole line, v steps on the line strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Lookahead line and cell row; arm execution at the first clean frame start
  // so a run cut by reset never reaches the colour latch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lv_cnt  <= '0;
      ly_sub  <= '0;
      ly_cell <= '0;
      armed   <= 1'b0;
    end else if (la_pre) begin
      if (v_last) begin
        lv_cnt  <= '0;
        ly_sub  <= '0;
        ly_cell <= '0;
        armed   <= 1'b1;
      end else begin
        lv_cnt <= v_cnt + VW'(1);
        if (ly_sub == SW'(NUM_INSTR - 1)) begin
          ly_sub  <= '0;
          ly_cell <= (ly_cell == YW'(CH - 1)) ? '0 : ly_cell + YW'(1);
        end else begin
          ly_sub <= ly_sub + SW'(1);
        end
      end
    end
  end

  // Lookahead column is inside the cell area either just before the line wrap
  // (cell 0) or in the first CW-1 cells of the current line.
  assign la_in     = (h_w >= H_LA_WRAP) || (h_w < H_EXE_END);
  assign execute_o = armed && la_in && (lv_w < V_CELLS);
  assign last_slot = (sub_q == SW'(NUM_INSTR - 1));

  // Instruction slot and cell column, cleared whenever execution stops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q <= '0;
      x_q   <= '0;
    end else if (!execute_o) begin
      sub_q <= '0;
      x_q   <= '0;
    end else if (last_slot) begin
      sub_q <= '0;
      x_q   <= (x_q == XW'(CW - 1)) ? '0 : x_q + XW'(1);
    end else begin
      sub_q <= sub_q + SW'(1);
    end
  end

  assign sub_o   = sub_q;
  assign x_pos_o = x_q;
  assign y_pos_o = ly_cell;

  // ---- stage p0 -> p1: executor result captured on the last slot ----
  assign vld_p0 = execute_o && last_slot;

  // Colour latch holds a finished cell for the NUM_INSTR pixels it covers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       rgb_p1 <= '0;
    else if (vld_p0) rgb_p1 <= rgb_i;
  end

  // Frame-stepped time value; mode is sampled on the frame strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      time_q   <= '0;
      dir_down <= 1'b0;
    end else if (next_frame_o) begin
      {dir_down, time_q} <= time_step(time_mode_i, time_q, dir_down);
    end
  end

  assign time_o       = time_q;
  assign next_line_o  = line_end;
  assign next_frame_o = line_end && v_last;
  assign hsync_o      = ((h_w >= HS_START) && (h_w < HS_END)) ? SYNC_POL : !SYNC_POL;
  assign vsync_o      = ((v_w >= VS_START) && (v_w < VS_END)) ? SYNC_POL : !SYNC_POL;

  // Only whole cells of the visible area are shown; the rest is blanked.
  assign vis = (h_w < H_CELLS) && (v_w < V_CELLS) && (h_w < H_VIS) && (v_w < V_VIS);

`ifdef SHADER_RASTER_GRID_EN
  logic [SW-1:0] hm_cnt;
  logic [SW-1:0] vm_cnt;
  logic          grid_hit;

  // Beam position modulo the cell edge, for the grid overlay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hm_cnt <= '0;
      vm_cnt <= '0;
    end else if (line_end) begin
      hm_cnt <= '0;
      if (v_last)                                vm_cnt <= '0;
      else if (vm_cnt == SW'(NUM_INSTR - 1))     vm_cnt <= '0;
      else                                       vm_cnt <= vm_cnt + SW'(1);
    end else begin
      hm_cnt <= (hm_cnt == SW'(NUM_INSTR - 1)) ? '0 : hm_cnt + SW'(1);
    end
  end

  assign grid_hit = grid_i && ((hm_cnt == '0) || (vm_cnt == '0));
`endif

  // Blanked display colour, with the optional grid drawn on top.
  always_comb begin
    rgb_o = '0;
    if (vis) begin
      rgb_o = rgb_p1;
`ifdef SHADER_RASTER_GRID_EN
      if (grid_hit) rgb_o = '1;
`endif
    end
  end

endmodule

// File: tb/tb_shader_raster_seq.sv
// Testbench for shader_raster_seq on a tiny raster so whole frames are cheap.
// Random executor colours are recorded per cycle and the expected display is
// derived from beam position arithmetic (cycle count -> h, v, lookahead).
module tb_shader_raster_seq;
  localparam int W = 8, H = 7, HF = 1, HS = 1, HB = 1, VF = 1, VS = 1, VB = 1;
  localparam int N = 3, CWD = 6;
  localparam bit POL = 1'b1;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int CW = W / N, CH = H / N;
  localparam int FRAME = HT * VT;
  localparam int T0 = (VT - 1) * HT + HT - N;
  localparam int SW = $clog2(N), XW = $clog2(CW), YW = $clog2(CH);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     mode = 2'b00;
  logic [CWD-1:0] rgb_in = '0;
  logic           grid_m = 1'b0;
  logic           execute;
  logic [SW-1:0]  sub;
  logic [XW-1:0]  x_pos;
  logic [YW-1:0]  y_pos;
  logic [7:0]     time_v;
  logic           hsync, vsync, nline, nframe;
  logic [CWD-1:0] rgb_out;

  shader_raster_seq #(
    .WIDTH(W), .HEIGHT(H), .HFRONT(HF), .HSYNC(HS), .HBACK(HB),
    .VFRONT(VF), .VSYNC(VS), .VBACK(VB), .SYNC_POL(POL),
    .NUM_INSTR(N), .COLOR_W(CWD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .time_mode_i(mode), .rgb_i(rgb_in),
`ifdef SHADER_RASTER_GRID_EN
    .grid_i(grid_m),
`endif
    .execute_o(execute), .sub_o(sub), .x_pos_o(x_pos), .y_pos_o(y_pos),
    .time_o(time_v), .hsync_o(hsync), .vsync_o(vsync),
    .next_line_o(nline), .next_frame_o(nframe), .rgb_o(rgb_out)
  );

  always #5 clk = ~clk;

  int             errors = 0;
  int             checks = 0;
  int             t = 0;
  logic [7:0]     time_m = 8'd0;
  bit             dir_m = 1'b0;
  logic [CWD-1:0] hist [64];

  // ---------------- reference model ----------------
  function automatic int hpos(input int tt); return tt % HT; endfunction
  function automatic int vpos(input int tt); return (tt / HT) % VT; endfunction
  function automatic int m_la(input int tt); return (hpos(tt) + N) % HT; endfunction
  function automatic int m_lv(input int tt);
    return (hpos(tt) + N >= HT) ? (vpos(tt) + 1) % VT : vpos(tt);
  endfunction
  function automatic bit m_exec(input int tt);
    return (tt >= T0) && (m_la(tt) < CW * N) && (m_lv(tt) < CH * N);
  endfunction
  function automatic int m_sub(input int tt);
    return m_exec(tt) ? m_la(tt) % N : 0;
  endfunction
  function automatic logic [CWD-1:0] m_rgb(input int tt);
    int h, v, ce;
    h = hpos(tt);
    v = vpos(tt);
    if (!(h < CW * N && v < CH * N)) return '0;
    if (grid_m && (h % N == 0 || v % N == 0)) return '1;
    ce = tt - (h % N) - 1;
    return (ce >= T0) ? hist[ce % 64] : '0;
  endfunction

  task automatic model_frame_tick(input logic [1:0] m);
    case (m)
      2'b01: time_m = time_m + 8'd1;
      2'b11: time_m = time_m - 8'd1;
      2'b10: begin
        if (!dir_m) begin
          time_m = time_m + 8'd1;
          if (time_m == 8'd255) dir_m = 1'b1;
        end else begin
          time_m = time_m - 8'd1;
          if (time_m == 8'd0) dir_m = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // One pixel clock: new random executor colour, outputs sampled at negedge.
  task automatic step();
    if (hpos(t) == HT - 1 && vpos(t) == VT - 1) model_frame_tick(mode);
    @(posedge clk);
    t++;
    #1;
    rgb_in = CWD'($urandom);
    hist[t % 64] = rgb_in;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input int pre_cycles, input int post_cycles);
    for (int i = 0; i < pre_cycles; i++) step();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rgb_out !== '0) begin errors++; $display("FAIL rst_rgb got=%0h exp=0", rgb_out); end
    checks++; if (time_v !== 8'd0) begin errors++; $display("FAIL rst_time got=%0d exp=0", time_v); end
    checks++; if (hsync !== !POL) begin errors++; $display("FAIL rst_hsync got=%0b exp=%0b", hsync, !POL); end
    checks++; if (vsync !== !POL) begin errors++; $display("FAIL rst_vsync got=%0b exp=%0b", vsync, !POL); end
    checks++; if (execute !== 1'b0) begin errors++; $display("FAIL rst_exec got=%0b exp=0", execute); end
    checks++; if (sub !== '0) begin errors++; $display("FAIL rst_sub got=%0d exp=0", sub); end
    checks++; if (nline !== 1'b0 || nframe !== 1'b0) begin
      errors++; $display("FAIL rst_strobes got=%0b%0b exp=00", nline, nframe);
    end
    rst = 1'b0;
    t = 0;
    time_m = 8'd0;
    dir_m = 1'b0;
    rgb_in = CWD'($urandom);
    hist[0] = rgb_in;
    for (int i = 0; i < post_cycles; i++) begin
      checks++; if (execute !== m_exec(t)) begin
        errors++; $display("FAIL post_rst_exec t=%0d got=%0b exp=%0b", t, execute, m_exec(t));
      end
      checks++; if (rgb_out !== m_rgb(t)) begin
        errors++; $display("FAIL post_rst_rgb t=%0d got=%0h exp=%0h", t, rgb_out, m_rgb(t));
      end
      checks++; if (time_v !== time_m) begin
        errors++; $display("FAIL post_rst_time t=%0d got=%0d exp=%0d", t, time_v, time_m);
      end
      step();
    end
  endtask

  task automatic test_scan(input int ncycles);
    int h, v;
    for (int i = 0; i < ncycles; i++) begin
      h = hpos(t);
      v = vpos(t);
      checks++; if (nline !== (h == HT - 1)) begin
        errors++; $display("FAIL scan_next_line t=%0d got=%0b exp=%0b", t, nline, h == HT - 1);
      end
      checks++; if (nframe !== (h == HT - 1 && v == VT - 1)) begin
        errors++; $display("FAIL scan_next_frame t=%0d got=%0b", t, nframe);
      end
      checks++; if (hsync !== ((h >= W + HF && h < W + HF + HS) ? POL : !POL)) begin
        errors++; $display("FAIL scan_hsync t=%0d h=%0d got=%0b", t, h, hsync);
      end
      checks++; if (vsync !== ((v >= H + VF && v < H + VF + VS) ? POL : !POL)) begin
        errors++; $display("FAIL scan_vsync t=%0d v=%0d got=%0b", t, v, vsync);
      end
      checks++; if (execute !== m_exec(t)) begin
        errors++; $display("FAIL scan_exec t=%0d got=%0b exp=%0b", t, execute, m_exec(t));
      end
      checks++; if (sub !== SW'(m_sub(t))) begin
        errors++; $display("FAIL scan_sub t=%0d got=%0d exp=%0d", t, sub, m_sub(t));
      end
      if (m_exec(t)) begin
        checks++; if (x_pos !== XW'(m_la(t) / N)) begin
          errors++; $display("FAIL scan_x_pos t=%0d got=%0d exp=%0d", t, x_pos, m_la(t) / N);
        end
        checks++; if (y_pos !== YW'(m_lv(t) / N)) begin
          errors++; $display("FAIL scan_y_pos t=%0d got=%0d exp=%0d", t, y_pos, m_lv(t) / N);
        end
      end
      checks++; if (rgb_out !== m_rgb(t)) begin
        errors++; $display("FAIL scan_rgb t=%0d h=%0d v=%0d got=%0h exp=%0h", t, h, v, rgb_out, m_rgb(t));
      end
      checks++; if (time_v !== time_m) begin
        errors++; $display("FAIL scan_time t=%0d got=%0d exp=%0d", t, time_v, time_m);
      end
      step();
    end
  endtask

  task automatic test_pingpong();
    mode = 2'b10;
    for (int f = 1; f <= 511; f++) begin
      repeat (FRAME) step();
      checks++; if (time_v !== time_m) begin
        errors++; $display("FAIL pingpong_frame f=%0d got=%0d exp=%0d", f, time_v, time_m);
      end
      if (f == 255) begin
        checks++; if (time_v !== 8'd255) begin errors++; $display("FAIL pingpong_top got=%0d exp=255", time_v); end
      end
      if (f == 256) begin
        checks++; if (time_v !== 8'd254) begin errors++; $display("FAIL pingpong_turn_down got=%0d exp=254", time_v); end
      end
      if (f == 510) begin
        checks++; if (time_v !== 8'd0) begin errors++; $display("FAIL pingpong_bottom got=%0d exp=0", time_v); end
      end
      if (f == 511) begin
        checks++; if (time_v !== 8'd1) begin errors++; $display("FAIL pingpong_turn_up got=%0d exp=1", time_v); end
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] frozen;
    mode = 2'b00;
    frozen = time_m;
    for (int f = 0; f < 3; f++) begin
      repeat (FRAME) step();
      checks++; if (time_v !== frozen) begin
        errors++; $display("FAIL hold_frozen f=%0d got=%0d exp=%0d", f, time_v, frozen);
      end
    end
  endtask

  task automatic test_wrap();
    mode = 2'b11;
    repeat (2 * FRAME) step();
    checks++; if (time_v !== 8'd255) begin errors++; $display("FAIL down_wrap got=%0d exp=255", time_v); end
    mode = 2'b01;
    repeat (FRAME) step();
    checks++; if (time_v !== 8'd0) begin errors++; $display("FAIL up_wrap got=%0d exp=0", time_v); end
    repeat (FRAME) step();
    checks++; if (time_v !== 8'd1) begin errors++; $display("FAIL up_step got=%0d exp=1", time_v); end
    checks++; if (time_v !== time_m) begin errors++; $display("FAIL wrap_model got=%0d exp=%0d", time_v, time_m); end
  endtask

`ifdef SHADER_RASTER_GRID_EN
  task automatic test_grid();
    grid_m = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      checks++; if (rgb_out !== m_rgb(t)) begin
        errors++; $display("FAIL grid_rgb t=%0d got=%0h exp=%0h", t, rgb_out, m_rgb(t));
      end
      step();
    end
    grid_m = 1'b0;
  endtask
`endif

  initial begin
    test_reset(0, 0);
    test_scan(3 * FRAME);
    test_pingpong();
    test_hold();
    test_wrap();
    test_reset(37, FRAME + 2 * HT);
`ifdef SHADER_RASTER_GRID_EN
    test_grid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
